// File: rtl/apb_ctrl_pkg.sv
// Shared types and constants for the APB requester-side controller.
// APB_TIMEOUT_EN sizes its ACCESS-phase watchdog from TO_CNT_W.
package apb_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } apb_state_e;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;
   localparam int TO_CNT_W   = 16;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter: search starts at the pointer, first asserted request wins,
// pointer moves past the winner only when the grant is taken (advance).
module apb_rr_arbiter #(
   parameter int NREQ  = 2,
   parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NREQ-1:0]  req,
   input  logic             advance,
   output logic [NREQ-1:0]  grant,
   output logic [IDX_W-1:0] grant_idx
);

   logic [IDX_W-1:0] ptr;
   logic             found;
   int               cand;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = 0;
      for (int k = 0; k < NREQ; k++) begin
         cand = (int'(ptr) + k) % NREQ;
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = IDX_W'(cand);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (advance && found) begin
         ptr <= (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + IDX_W'(1);
      end
   end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB bus between NREQ requesters: RR arbitration, SETUP/ACCESS/DONE sequencing.
// Define APB_TIMEOUT_EN to bound the ACCESS phase to TIMEOUT cycles (rsp_err on expiry).
module apb_master_arbiter
   import apb_ctrl_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ-1:0]        req_write,
   input  logic [NREQ*ADDR_W-1:0] req_addr,
   input  logic [NREQ*DATA_W-1:0] req_wdata,
   output logic [NREQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]      rsp_rdata,
   output logic                   rsp_err,
   output logic [ADDR_W-1:0]      PADDR,
   output logic [DATA_W-1:0]      PWDATA,
   output logic                   PWRITE,
   output logic                   PSEL,
   output logic                   PENABLE,
   input  logic [DATA_W-1:0]      PRDATA,
   input  logic                   PREADY
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   apb_state_e       state, state_nxt;
   logic [NREQ-1:0]  grant;
   logic [IDX_W-1:0] grant_idx, gidx_q;
   logic             any_req, accept, timeout_hit;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, rdata_q;
   logic              write_q;

   assign any_req = |req_valid;
   assign accept  = (state == IDLE) && any_req;

   apb_rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req_valid),
      .advance   (accept),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

`ifdef APB_TIMEOUT_EN
   logic [TO_CNT_W-1:0] to_cnt;
   logic                err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt <= '0;
      end else if (state == SETUP) begin
         to_cnt <= '0;
      end else if (state == ACCESS && !PREADY) begin
         to_cnt <= to_cnt + TO_CNT_W'(1);
      end
   end

   // Expiry is the ACCESS cycle whose stall would bring the count to TIMEOUT; PREADY wins.
   assign timeout_hit = (state == ACCESS) && !PREADY && (to_cnt == TO_CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (state == ACCESS && (PREADY || timeout_hit)) begin
         err_q <= timeout_hit;
      end
   end

   assign rsp_err = (state == DONE) && err_q;
`else
   assign timeout_hit = 1'b0;
   assign rsp_err     = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = SETUP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (PREADY || timeout_hit) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      PSEL      = 1'b0;
      PENABLE   = 1'b0;
      case (state)
         IDLE:   req_ready = grant;
         SETUP:  PSEL = 1'b1;
         ACCESS: begin
            PSEL    = 1'b1;
            PENABLE = 1'b1;
         end
         DONE: begin
            for (int i = 0; i < NREQ; i++) begin
               rsp_valid[i] = (gidx_q == IDX_W'(i));
            end
         end
         default: ;
      endcase
   end

   // Request payload is captured at the handshake and held on the bus until the next grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
         gidx_q  <= '0;
      end else if (accept) begin
         addr_q  <= req_addr[int'(grant_idx) * ADDR_W +: ADDR_W];
         wdata_q <= req_wdata[int'(grant_idx) * DATA_W +: DATA_W];
         write_q <= req_write[grant_idx];
         gidx_q  <= grant_idx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else if (state == ACCESS) begin
         if (PREADY) begin
            if (!write_q) rdata_q <= PRDATA;
         end else if (timeout_hit) begin
            rdata_q <= '0;
         end
      end
   end

   assign PADDR     = addr_q;
   assign PWDATA    = wdata_q;
   assign PWRITE    = write_q;
   assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter with a registered-PREADY register-file slave.
// Timeout checks are compiled in when APB_TIMEOUT_EN is defined.
module tb_apb_master_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_valid, req_ready, req_write, rsp_valid;
   logic [63:0] req_addr, req_wdata;
   logic [31:0] rsp_rdata, PADDR, PWDATA, PRDATA;
   logic        rsp_err, PWRITE, PSEL, PENABLE, PREADY;

   int n_chk = 0;
   int n_bad = 0;

   apb_master_arbiter #(.NREQ(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
      .PRDATA(PRDATA), .PREADY(PREADY)
   );

   always #5 clk = ~clk;

   // Register-file slave; PREADY rises one cycle after PSEL&PENABLE plus stall_cfg cycles.
   logic [31:0] mem [0:15];
   int          stall_cfg = 0;
   int          wait_left;
   bit          stuck = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         PREADY    <= 1'b0;
         PRDATA    <= '0;
         wait_left <= 0;
      end else if (PSEL && !PENABLE) begin
         wait_left <= stall_cfg;
      end else if (PSEL && PENABLE && !PREADY) begin
         if (stuck) begin
            PREADY <= 1'b0;
         end else if (wait_left > 0) begin
            wait_left <= wait_left - 1;
         end else begin
            PREADY <= 1'b1;
            if (PWRITE) mem[PADDR[3:0]] <= PWDATA;
            else        PRDATA <= mem[PADDR[3:0]];
         end
      end else begin
         PREADY <= 1'b0;
      end
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge in IDLE; returns at the negedge after the handshake (SETUP).
   task automatic issue(input int idx, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, output bit ok);
      logic [1:0] exp_rdy;
      exp_rdy = 2'b01 << idx;
      req_write[idx]            = wr;
      req_addr[idx*32 +: 32]    = addr;
      req_wdata[idx*32 +: 32]   = wd;
      req_valid[idx]            = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 50; t++) begin
         #1;
         if (req_ready != 2'b00) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (ok) begin
         check_val("ready onehot", req_ready, exp_rdy);
         @(negedge clk);
      end else begin
         check_val("accept", 0, 1);
      end
      req_valid[idx] = 1'b0;
   endtask

   task automatic wait_rsp(input int idx, output int lat);
      lat = 1;
      while (!rsp_valid[idx] && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      if (!rsp_valid[idx]) check_val("rsp_valid wait", 0, 1);
   endtask

   task automatic xfer(input int idx, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd, output logic er);
      bit ok;
      issue(idx, wr, addr, wd, ok);
      lat = 0;
      rd  = '0;
      er  = 1'b0;
      if (ok) begin
         wait_rsp(idx, lat);
         rd = rsp_rdata;
         er = rsp_err;
         @(negedge clk);
      end
   endtask

   initial begin
      int          lat, low, gcnt;
      bit          ok, stable;
      logic [31:0] rd;
      logic        er;
      logic [1:0]  gseq [4];
      int          gcyc [4];

      for (int i = 0; i < 16; i++) mem[i] = '0;
      rst_n = 1'b0;
      req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      repeat (3) @(negedge clk);
      check_val("rst PSEL", PSEL, 0);
      check_val("rst PENABLE", PENABLE, 0);
      check_val("rst PADDR", PADDR, 0);
      check_val("rst rsp_valid", rsp_valid, 0);
      check_val("rst rsp_rdata", rsp_rdata, 0);
      check_val("rst rsp_err", rsp_err, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check_val("idle ready", req_ready, 0);

      // Single write
      issue(0, 1'b1, 32'd2, 32'hCAFE_F00D, ok);
      check_val("setup PSEL", PSEL, 1);
      check_val("setup PENABLE", PENABLE, 0);
      check_val("setup PADDR", PADDR, 2);
      check_val("setup PWDATA", PWDATA, 32'hCAFE_F00D);
      check_val("setup PWRITE", PWRITE, 1);
      wait_rsp(0, lat);
      check_val("write latency", lat, 4);
      check_val("write err", rsp_err, 0);
      @(negedge clk);
      check_val("mem[2]", mem[2], 32'hCAFE_F00D);

      // Read-back, then a write must leave rsp_rdata alone
      xfer(0, 1'b1, 32'd3, 32'h1234_5678, lat, rd, er);
      xfer(0, 1'b0, 32'd3, 32'h0, lat, rd, er);
      check_val("readback data", rd, 32'h1234_5678);
      check_val("readback err", er, 0);
      check_val("read latency", lat, 4);
      xfer(0, 1'b1, 32'd5, 32'hDEAD_0000, lat, rd, er);
      check_val("write keeps rdata", rd, 32'h1234_5678);

      // Stall: PREADY low for 6 ACCESS cycles
      stall_cfg = 5;
      issue(1, 1'b0, 32'd2, 32'h0, ok);
      check_val("stall setup", {PSEL, PENABLE}, 2'b10);
      @(negedge clk);
      low = 0;
      stable = 1'b1;
      for (int t = 0; t < 40; t++) begin
         if (PREADY) break;
         low++;
         if (!(PSEL && PENABLE && PADDR == 32'd2)) stable = 1'b0;
         @(negedge clk);
      end
      check_val("stall low cycles", low, 6);
      check_val("stall bus stable", stable, 1);
      @(negedge clk);
      check_val("stall rsp_valid", rsp_valid, 2'b10);
      check_val("stall rdata", rsp_rdata, 32'hCAFE_F00D);
      @(negedge clk);

      // Reset in ACCESS (grant to 0 moves pointer to 1 before reset)
      issue(0, 1'b0, 32'd2, 32'h0, ok);
      @(negedge clk);
      check_val("pre-reset PENABLE", PENABLE, 1);
      #2 rst_n = 1'b0;
      #1;
      check_val("reset drops bus", {PSEL, PENABLE}, 2'b00);
      @(negedge clk);
      check_val("reset no rsp", rsp_valid, 0);
      stall_cfg = 0;
      req_write = 2'b11;
      req_addr  = {32'd7, 32'd6};
      req_wdata = {32'hB1B1_B1B1, 32'hA0A0_A0A0};
      rst_n = 1'b1;
      req_valid = 2'b11;

      // Contention: expect 0,1,0,1 with 5-cycle spacing
      gcnt = 0;
      for (int t = 0; t < 80 && gcnt < 4; t++) begin
         #1;
         if (req_ready != 2'b00) begin
            gseq[gcnt] = req_ready;
            gcyc[gcnt] = t;
            gcnt++;
         end
         if (gcnt < 4) @(negedge clk);
      end
      check_val("grant count", gcnt, 4);
      if (gcnt == 4) begin
         check_val("grant 0", gseq[0], 2'b01);
         check_val("grant 1", gseq[1], 2'b10);
         check_val("grant 2", gseq[2], 2'b01);
         check_val("grant 3", gseq[3], 2'b10);
         check_val("spacing", gcyc[1] - gcyc[0], 5);
      end
      @(negedge clk);
      req_valid = 2'b10;
      ok = 1'b0;
      for (int t = 0; t < 20; t++) begin
         #1;
         if (req_ready != 2'b00) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check_val("lone req1 grant", req_ready, 2'b10);
      @(negedge clk);
      req_valid = 2'b00;
      if (ok) wait_rsp(1, lat);
      repeat (2) @(negedge clk);
      check_val("mem[6]", mem[6], 32'hA0A0_A0A0);
      check_val("mem[7]", mem[7], 32'hB1B1_B1B1);

`ifdef APB_TIMEOUT_EN
      xfer(0, 1'b0, 32'd2, 32'h0, lat, rd, er);
      check_val("pre-timeout read", rd, 32'hCAFE_F00D);
      stuck = 1'b1;
      xfer(0, 1'b0, 32'd2, 32'h0, lat, rd, er);
      check_val("timeout latency", lat, 18);
      check_val("timeout err", er, 1);
      check_val("timeout rdata", rd, 0);
      stuck = 1'b0;
      xfer(1, 1'b0, 32'd3, 32'h0, lat, rd, er);
      check_val("post-timeout err", er, 0);
      check_val("post-timeout data", rd, 32'h1234_5678);
      check_val("post-timeout latency", lat, 4);
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
APB requester-side controller that shares a single APB bus between NREQ independent requesters, such as the UART command decoder and a debug/config port. It uses round-robin arbitration and runs the APB SETUP/ACCESS phases. It waits on PREADY and returns read data and a completion pulse to the granted requester. It drives the register-file APB slave directly.

Parameters:
NREQ, 2, number of requesters (2..8)
ADDR_W, 32, APB address width
DATA_W, 32, APB data width
TIMEOUT, 16, ACCESS-phase cycle limit (used only with APB_TIMEOUT_EN)

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  NREQ  per-requester transfer request
req_ready  out  NREQ  one-hot; transfer accepted when valid&ready
req_write  in  NREQ  1=write, 0=read, per requester
req_addr  in  NREQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NREQ*DATA_W  packed write data, same packing
rsp_valid  out  NREQ  one-cycle completion pulse to the owning requester
rsp_rdata  out  DATA_W  read data, valid with rsp_valid (shared)
rsp_err  out  1  error flag, valid with rsp_valid
PADDR  out  ADDR_W  APB address
PWDATA  out  DATA_W  APB write data
PWRITE  out  1  APB direction
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PRDATA  in  DATA_W  APB read data
PREADY  in  1  APB ready (slave-registered)

Behaviour:
- Reset (async, rst_n=0): state IDLE, all outputs 0, RR pointer=0, pending transfer discarded, no rsp_valid. Reset mid-transfer drops PSEL/PENABLE immediately.
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - req_ready = onehot(grant) when any req_valid, combinational from req_valid and pointer; otherwise 0.
  - On handshake, latch addr/wdata/write/grant index → SETUP.
- SETUP (1 cycle): PSEL=1, PENABLE=0, PADDR/PWDATA/PWRITE = latched values → ACCESS.
- ACCESS: PSEL=1, PENABLE=1. Stay while PREADY=0.
  - On PREADY=1, capture PRDATA into rsp_rdata (reads only; writes leave rsp_rdata unchanged) → DONE.
- DONE (1 cycle):
  - PSEL=PENABLE=0; rsp_valid[grant]=1, rsp_err per timeout.
  - The idle gap lets the slave's registered PREADY fall before the next SETUP.
  - → IDLE.
- PREADY is ignored outside ACCESS.
- PADDR/PWDATA/PWRITE hold their last values in IDLE/DONE.
- Latency with a slave whose PREADY is registered one cycle after PSEL&PENABLE: accept→rsp_valid = 4 cycles (SETUP, ACCESS×2, DONE).
- Minimum request-to-request spacing: 5 cycles.
- Round-robin:
  - Search starts at pointer; first asserted req_valid wins.
  - After a grant to i, pointer = (i+1) mod NREQ. The pointer does not move without a grant.
- Requester rules: req_valid and its payload must hold until req_ready. A requester may issue a new request in the cycle after its rsp_valid.
- Simultaneous events:
  - All requesters valid in IDLE → exactly one req_ready bit.
  - A new req_valid during SETUP/ACCESS/DONE waits; req_ready=0 in those states.

Optional Feature:
Macro APB_TIMEOUT_EN.
- Defined: a counter clears on SETUP→ACCESS and increments each ACCESS cycle with PREADY=0. When it reaches TIMEOUT, the controller goes to DONE with rsp_err=1 and rsp_rdata=0. PREADY on the same cycle as expiry wins, giving a normal completion with rsp_err=0.
- Undefined: no counter; ACCESS waits indefinitely; rsp_err tied 0.

Decomposition:
- Package apb_ctrl_pkg: state enum (IDLE, SETUP, ACCESS, DONE), ADDR_W/DATA_W defaults, timeout counter width constant.
- Sub-module apb_rr_arbiter: NREQ-wide round-robin arbiter; inputs req, advance, clk, rst_n; outputs one-hot grant and grant index.
- The top holds the FSM, latches and timeout.

Test Plan:
- Single write: req0 write addr=2 wdata=0xCAFE_F00D → req_ready[0] 1 cycle; SETUP PSEL=1 PENABLE=0; PENABLE=1 until PREADY; rsp_valid[0] pulse 4 cycles after accept; slave reg[2]=0xCAFE_F00D.
- Read-back: write 0x1234_5678 to addr 3, then read addr 3 → rsp_rdata=0x1234_5678, rsp_err=0.
- Contention: req0 and req1 valid together from reset → grant order 0,1,0,1 over four transfers. Then with only req1 valid after a grant to 1 → req1 is granted again.
- Stall: slave holds PREADY=0 for 6 cycles → PSEL/PENABLE/PADDR stable throughout; rsp_valid on the cycle after PREADY is sampled.
- Timeout (APB_TIMEOUT_EN, TIMEOUT=16): PREADY stuck 0 → DONE after 16 ACCESS cycles; rsp_err=1, rsp_rdata=0; the next request proceeds normally.
- Reset in ACCESS: rst_n low mid-transfer → PSEL=PENABLE=0 immediately, no rsp_valid; after release, pointer=0 and req0 is granted first.
